clk_div_bank: RTL and testbench

Parametrised bank of `N_CH` independent programmable frequency dividers driven from the 100 MHz board clock. It is the successor to the fixed 1 kHz divider. Each channel produces:
- a divided clock level (near-50 % duty);
- a one-cycle `tick` enable for logic in the `CLK100MHZ` domain.

Divisors are runtime-writable with glitch-free reload at period boundaries. A global `sync` re-phases all channels. It sits between the board clock and the pipeline's slow consumers (display scan, debouncers, step clocks).

---
 rtl/clk_div_pkg.sv | 37 +++
 rtl/clk_div_bank_if.sv | 30 +++
 rtl/clk_div_ch.sv | 93 +++++++++
 rtl/clk_div_bank.sv | 64 ++++++
 tb/tb_clk_div_bank.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock divider bank.
package clk_div_pkg;

  localparam int unsigned DIV_MIN    = 32'd2;
  localparam int unsigned DFLT_CNT_W = 32'd20;
  localparam int unsigned DFLT_DIV   = 32'd100_000;

  // Per-channel registered outputs, bundled for the bank-level fan-in.
  typedef struct packed {
    logic pend;
    logic tick;
    logic clk_out;
  } ch_stat_t;

  // Divisors of 0 or 1 would make the terminal count unreachable or degenerate.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    logic [31:0] r;
    if (v < DIV_MIN) begin
      r = DIV_MIN;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Channel index width, at least one bit even for a single-channel bank.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    int unsigned r;
    if (n > 32'd1) begin
      r = $clog2(n);
    end else begin
      r = 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Control/status bundle between the divider bank and its host logic.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = DFLT_CNT_W
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  clk_out;

  modport master (
    output en, sync, wr, wr_ch, wr_div,
    input  pend, tick, clk_out
  );

  modport slave (
    input  en, sync, wr, wr_ch, wr_div,
    output pend, tick, clk_out
  );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow divisor with boundary-only reload,
// and the registered tick / divided-clock outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = DFLT_CNT_W,
  parameter int unsigned DEF_DIV = DFLT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output ch_stat_t         stat
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_V    = CNT_W'(0);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] div_pend_r;
  logic             pend_r;
  logic             tick_r;
  logic             clk_out_r;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] div_nxt_s;
  logic [CNT_W-1:0] div_pend_nxt_s;
  logic             pend_nxt_s;
  logic             tc_s;
  logic             restart_s;
  logic             boundary_s;

  // Next-state: counter wrap/restart and divisor reload at period boundaries.
  always_comb begin
    tc_s           = en && (cnt_r == (div_r - ONE_V));
    restart_s      = en && (tc_s || sync);
    // A stopped channel has no phase to protect, so reloads land immediately.
    boundary_s     = restart_s || !en;
    cnt_nxt_s      = ZERO_V;
    div_nxt_s      = div_r;
    div_pend_nxt_s = div_pend_r;
    pend_nxt_s     = pend_r;

    if (en && !restart_s) begin
      cnt_nxt_s = cnt_r + ONE_V;
    end else begin
      cnt_nxt_s = ZERO_V;
    end

    if (wr) begin
      div_pend_nxt_s = wr_div;
      if (boundary_s) begin
        div_nxt_s  = wr_div;
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = 1'b1;
      end
    end else if (boundary_s && pend_r) begin
      div_nxt_s  = div_pend_r;
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // State and output registers; the high phase is the first div/2 counts of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= ZERO_V;
      div_r      <= DEF_DIV_V;
      div_pend_r <= DEF_DIV_V;
      pend_r     <= 1'b0;
      tick_r     <= 1'b0;
      clk_out_r  <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      div_r      <= div_nxt_s;
      div_pend_r <= div_pend_nxt_s;
      pend_r     <= pend_nxt_s;
      tick_r     <= restart_s;
      clk_out_r  <= en && (cnt_nxt_s < (div_nxt_s >> 1'b1));
    end
  end

  assign stat.pend    = pend_r;
  assign stat.tick    = tick_r;
  assign stat.clk_out = clk_out_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable dividers off the 100 MHz board clock, with a
// shared divisor write port and a global re-phase pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CNT_W   = DFLT_CNT_W,
  parameter int unsigned DEF_DIV = DFLT_DIV
) (
  input  logic           CLK100MHZ,
  input  logic           CPU_RESETN,
  clk_div_bank_if.slave  bus
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic [CNT_W-1:0] wr_div_s;
  logic [N_CH-1:0]  wr_sel_s;
  logic [N_CH-1:0]  pend_s;
  logic [N_CH-1:0]  tick_s;
  logic [N_CH-1:0]  clk_out_s;
  ch_stat_t         stat_s [N_CH];

  // Clamp once for all channels; indices beyond N_CH-1 select nothing.
  always_comb begin
    wr_div_s = CNT_W'(clamp_div(32'(bus.wr_div)));
    wr_sel_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      wr_sel_s[i] = bus.wr && (bus.wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .en     (bus.en[g]),
      .sync   (bus.sync),
      .wr     (wr_sel_s[g]),
      .wr_div (wr_div_s),
      .stat   (stat_s[g])
    );
  end

  // Gather per-channel status into the bus vectors.
  always_comb begin
    pend_s    = {N_CH{1'b0}};
    tick_s    = {N_CH{1'b0}};
    clk_out_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      pend_s[i]    = stat_s[i].pend;
      tick_s[i]    = stat_s[i].tick;
      clk_out_s[i] = stat_s[i].clk_out;
    end
  end

  assign bus.pend    = pend_s;
  assign bus.tick    = tick_s;
  assign bus.clk_out = clk_out_s;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed scoreboard bench for clk_div_bank: expected per-cycle tick/clk_out/pend
// values are queued from period arithmetic and compared one ns after each edge.
module tb_clk_div_bank;

  localparam int unsigned N_CH  = 2;
  localparam int unsigned CNT_W = 20;
  localparam int unsigned DDIV  = 12;

  typedef struct {
    int         cyc;
    int         ch;
    bit         is_pend;
    logic [1:0] exp;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb [$];

  clk_div_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(
    .N_CH    (N_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DDIV)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input bit is_pend, input logic [1:0] v, input string tag);
    exp_t e;
    e.cyc = c; e.ch = ch; e.is_pend = is_pend; e.exp = v; e.tag = tag;
    sb.push_back(e);
  endtask

  // One period of divisor d: tick on its first cycle, clk_out high for d/2 cycles.
  task automatic exp_period(input int ch, input int d, input int start, input int len, input string tag);
    for (int k = 0; k < len; k++) push(start + k, ch, 1'b0, {(k == 0), (k < d / 2)}, tag);
  endtask

  // Enable at edge 'start' from cnt 0: partial lead-in of d-1 cycles, then full periods.
  task automatic exp_start(input int ch, input int d, input int start, input int nper, input string tag);
    for (int j = 0; j < d - 1; j++) push(start + j, ch, 1'b0, {1'b0, ((j + 1) < d / 2)}, tag);
    for (int p = 0; p < nper; p++) exp_period(ch, d, start + d - 1 + p * d, d, tag);
  endtask

  task automatic exp_zero(input int ch, input int start, input int len, input string tag);
    for (int k = 0; k < len; k++) push(start + k, ch, 1'b0, 2'b00, tag);
  endtask

  task automatic exp_pend(input int ch, input int start, input int len, input logic v, input string tag);
    for (int k = 0; k < len; k++) push(start + k, ch, 1'b1, {1'b0, v}, tag);
  endtask

  task automatic step();
    logic [1:0] obs;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].is_pend) obs = {1'b0, bus.pend[sb[i].ch]};
        else               obs = {bus.tick[sb[i].ch], bus.clk_out[sb[i].ch]};
        n_checks++;
        assert (obs === sb[i].exp) else begin
          n_err++;
          $error("FAIL %s ch%0d cyc %0d: observed %b expected %b", sb[i].tag, sb[i].ch, cyc, obs, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_write(input int ch, input int val);
    bus.wr     = 1'b1;
    bus.wr_ch  = 1'(ch);
    bus.wr_div = 20'(val);
    step();
    bus.wr     = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
  endtask

  task automatic setup_div(input int ch, input int d);
    bus.en[ch] = 1'b0;
    do_write(ch, d);
    step();
    step();
  endtask

  initial begin
    int e0;
    cyc = 0; n_checks = 0; n_err = 0;
    rst_n = 1'b0;
    bus.en = 2'b00; bus.sync = 1'b0; bus.wr = 1'b0; bus.wr_ch = 1'b0; bus.wr_div = 20'd0;
    #12;
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    step(); step();
    rst_n = 1'b1;
    exp_zero(0, cyc + 1, 2, "idle0"); exp_zero(1, cyc + 1, 2, "idle1");
    exp_pend(0, cyc + 1, 2, 1'b0, "idle_pend");
    step(); step();

    // Default divisor on both channels from a common enable.
    bus.en = 2'b11; e0 = cyc + 1;
    exp_start(0, DDIV, e0, 2, "dflt0"); exp_start(1, DDIV, e0, 2, "dflt1");
    exp_pend(0, e0, 35, 1'b0, "dflt_pend");
    run_to(e0 + 34);

    // D=8, write 5 mid-period, then writes of 0 and 1 clamp to 2.
    setup_div(0, 8);
    bus.en[0] = 1'b1; e0 = cyc + 1;
    exp_start(0, 8, e0, 1, "d8");
    for (int p = 0; p < 3; p++) exp_period(0, 5, e0 + 15 + p * 5, 5, "d5");
    for (int p = 0; p < 3; p++) exp_period(0, 2, e0 + 30 + p * 2, 2, "d2");
    exp_pend(0, e0 + 8, 1, 1'b0, "pend5_pre"); exp_pend(0, e0 + 9, 6, 1'b1, "pend5");
    exp_pend(0, e0 + 15, 11, 1'b0, "pend5_clr"); exp_pend(0, e0 + 26, 4, 1'b1, "pend2");
    exp_pend(0, e0 + 30, 6, 1'b0, "pend2_clr");
    run_to(e0 + 8); do_write(0, 5);
    run_to(e0 + 25); do_write(0, 0); do_write(0, 1);
    run_to(e0 + 35);

    // D=10, write on terminal count bypasses shadow; then last of two writes wins.
    setup_div(0, 10);
    bus.en[0] = 1'b1; e0 = cyc + 1;
    exp_start(0, 10, e0, 1, "d10");
    for (int p = 0; p < 3; p++) exp_period(0, 4, e0 + 19 + p * 4, 4, "tc_wr4");
    for (int p = 0; p < 3; p++) exp_period(0, 3, e0 + 31 + p * 3, 3, "last3");
    exp_pend(0, e0 + 17, 11, 1'b0, "tc_nopend"); exp_pend(0, e0 + 28, 3, 1'b1, "pend63");
    exp_pend(0, e0 + 31, 9, 1'b0, "pend63_clr");
    run_to(e0 + 18); do_write(0, 4);
    run_to(e0 + 27); do_write(0, 6); do_write(0, 3);
    run_to(e0 + 39);

    // Sync alignment, sync on terminal count, disabled channel, then async reset.
    bus.en = 2'b00;
    do_write(0, 7); do_write(1, 4); step(); step();
    bus.en = 2'b11; e0 = cyc + 1;
    exp_start(0, 7, e0, 0, "s7_pre"); exp_period(0, 7, e0 + 6, 3, "s7_a");
    exp_period(0, 7, e0 + 9, 4, "s7_sync"); exp_period(0, 7, e0 + 13, 7, "s7_tcsync");
    exp_period(0, 7, e0 + 20, 2, "s7_c"); exp_period(0, 7, e0 + 22, 7, "s7_sync2");
    exp_period(0, 7, e0 + 29, 2, "s7_d"); exp_zero(0, e0 + 31, 2, "dis0");
    exp_start(1, 4, e0, 1, "s4_pre"); exp_period(1, 4, e0 + 7, 2, "s4_a");
    exp_period(1, 4, e0 + 9, 4, "s4_sync"); exp_period(1, 4, e0 + 13, 4, "s4_tcsync");
    exp_zero(1, e0 + 17, 12, "dis1");
    push(e0 + 33, 0, 1'b0, 2'b01, "reen0"); push(e0 + 34, 0, 1'b0, 2'b01, "reen0");
    push(e0 + 33, 1, 1'b0, 2'b01, "reen1"); push(e0 + 34, 1, 1'b0, 2'b00, "reen1");
    exp_pend(0, e0 + 33, 1, 1'b0, "pre_rst_pend"); exp_pend(0, e0 + 34, 1, 1'b1, "pre_rst_pend");
    run_to(e0 + 8); pulse_sync();
    run_to(e0 + 12); pulse_sync();
    run_to(e0 + 16); bus.en[1] = 1'b0;
    run_to(e0 + 21); pulse_sync();
    run_to(e0 + 30); bus.en = 2'b00;
    run_to(e0 + 32); bus.en = 2'b11;
    step(); do_write(0, 3);
    #3; rst_n = 1'b0; #1;
    chk("async_rst_tick", 32'(bus.tick), 32'd0);
    chk("async_rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("async_rst_pend", 32'(bus.pend), 32'd0);
    bus.en = 2'b00;
    step(); step();
    rst_n = 1'b1;
    bus.en = 2'b11; e0 = cyc + 1;
    exp_start(0, DDIV, e0, 1, "post_rst0"); exp_start(1, DDIV, e0, 1, "post_rst1");
    exp_pend(0, e0, 23, 1'b0, "post_rst_pend");
    run_to(e0 + 22);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
